// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART feeder.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    WAIT,
    DONE
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Finalise a running byte sum into the checksum byte, so that the whole
  // frame (header, payload, checksum) sums to zero modulo 256.
  function automatic logic [7:0] checksum_fin(input logic [7:0] acc);
    return 8'h00 - acc;
  endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Request side and byte-transmitter handshake of the framed UART feeder.
// The master side is the environment (telemetry logic plus the byte
// transmitter's idle flag); the slave side is the frame builder itself.
interface uart_frame_tx_if #(
  parameter int PAYLOAD_BYTES = 3
);

  logic                         send;
  logic [8*PAYLOAD_BYTES-1:0]   payload;
  logic                         busy;
  logic                         frame_done;
  logic                         trmt;
  logic [7:0]                   tx_data;
  logic                         tx_done;

  modport master (
    output send,
    output payload,
    output tx_done,
    input  busy,
    input  frame_done,
    input  trmt,
    input  tx_data
  );

  modport slave (
    input  send,
    input  payload,
    input  tx_done,
    output busy,
    output frame_done,
    output trmt,
    output tx_data
  );

endinterface

// File: rtl/uart_frame_tx.sv
// Frame builder in front of the byte-level UART transmitter. A single-cycle
// send captures the payload word; the block then hands out header, payload
// bytes (MSB first) and a zero-sum checksum one at a time, waiting for the
// transmitter's tx_done between bytes.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 3,
  parameter logic [7:0] HEADER        = HEADER_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  uart_frame_tx_if.slave bus
);

  localparam int                PW       = 8 * PAYLOAD_BYTES;
  localparam int                IDX_W    = $clog2(PAYLOAD_BYTES + 2);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PAYLOAD_BYTES + 1);

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   next_idx;
  logic [7:0]         acc;
  logic [7:0]         next_byte;
  logic [7:0]         tx_data_q;
  logic [PW-1:0]      shadow;
  logic               start_frame;
  logic               advance;

  // State register; reset drops any frame in flight back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Sequencing: accept a request only when the transmitter is idle, pulse
  // trmt in LOAD, skip one cycle in ARM while tx_done is still stale, then
  // wait for the byte to finish before loading the next one.
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    advance     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.send && bus.tx_done) begin
          start_frame = 1'b1;
          next_state  = LOAD;
        end
      end
      LOAD: next_state = ARM;
      ARM:  next_state = WAIT;
      WAIT: begin
        if (bus.tx_done) begin
          if (idx == LAST_IDX) begin
            next_state = DONE;
          end else begin
            advance    = 1'b1;
            next_state = LOAD;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Byte selection for the upcoming slot: payload bytes MSB first, and the
  // finalised checksum once the index runs past the payload.
  always_comb begin
    next_idx  = idx + 1'b1;
    next_byte = checksum_fin(acc);
    for (int i = 1; i <= PAYLOAD_BYTES; i++) begin
      if (next_idx == IDX_W'(i)) next_byte = shadow[PW-8*(i-1)-1 -: 8];
    end
  end

  // Datapath: shadow copy of the payload, byte index, running sum and the
  // registered byte presented to the transmitter (held between loads).
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      idx       <= '0;
      acc       <= 8'h00;
      tx_data_q <= 8'h00;
    end else if (start_frame) begin
      shadow    <= bus.payload;
      idx       <= '0;
      acc       <= HEADER;
      tx_data_q <= HEADER;
    end else if (advance) begin
      idx       <= next_idx;
      acc       <= acc + next_byte;
      tx_data_q <= next_byte;
    end
  end

  assign bus.trmt       = (state == LOAD);
  assign bus.busy       = (state == LOAD) || (state == ARM) || (state == WAIT);
  assign bus.frame_done = (state == DONE);
  assign bus.tx_data    = tx_data_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: table of payloads with hand-computed
// frames, plus sequences for mid-frame requests and reset during a byte.
module tb_uart_frame_tx;
  import uart_pkg::*;

  localparam int PB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_frame_tx_if #(.PAYLOAD_BYTES(PB)) bus ();

  uart_frame_tx #(.PAYLOAD_BYTES(PB), .HEADER(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Byte transmitter stand-in: tx_done drops the cycle after trmt and stays
  // low for 20 cycles; it is not affected by rst.
  logic tx_done_m = 1'b1;
  int   tx_cnt    = 0;
  assign bus.tx_done = tx_done_m;

  always @(posedge clk) begin
    if (bus.trmt) begin
      tx_cnt    <= 20;
      tx_done_m <= 1'b0;
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_done_m <= 1'b1;
    end
  end

  // Monitor: record every byte handed over and flag protocol violations.
  logic [7:0] cap [128];
  int   cap_cnt   = 0;
  int   fd_cnt    = 0;
  int   viol_cnt  = 0;
  int   b2b_cnt   = 0;
  logic trmt_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.trmt) begin
      if (cap_cnt < 128) cap[cap_cnt] = bus.tx_data;
      cap_cnt++;
      if (!tx_done_m) viol_cnt++;
      if (trmt_prev) b2b_cnt++;
    end
    if (bus.frame_done) fd_cnt++;
    trmt_prev = bus.trmt;
  end

  typedef struct {
    logic [23:0] payload;
    logic [39:0] frame;
    int          mode;   // 0 plain, 1 resend + new payload mid-frame, 2 send during DONE
  } vec_t;

  vec_t vecs [6];

  function automatic logic [39:0] model_frame(input logic [23:0] p);
    logic [7:0] s;
    s = 8'hA5 + p[23:16] + p[15:8] + p[7:0];
    return {8'hA5, p, checksum_fin(s)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] p);
    @(posedge clk);
    #1;
    bus.payload = p;
    bus.send    = 1'b1;
    @(posedge clk);
    #1;
    bus.send    = 1'b0;
  endtask

  // Send one frame and check every byte, busy, frame_done and the quiet
  // period afterwards.
  task automatic runFrame(input string name, input logic [23:0] p,
                          input logic [39:0] exp, input int mode);
    int         base;
    int         fd0;
    int         busy_bad;
    logic       done_ok;
    logic       resent;
    logic [7:0] s;
    base     = cap_cnt;
    fd0      = fd_cnt;
    busy_bad = 0;
    done_ok  = 1'b0;
    resent   = 1'b0;
    applyStimulus(p);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      #1;
      if (fd_cnt > fd0) begin
        done_ok = 1'b1;
        checkOutput($sformatf("%s busy at frame_done", name), 32'(bus.busy), 32'd0);
        if (mode == 2) begin
          bus.send = 1'b1;
          @(posedge clk);
          #1;
          bus.send = 1'b0;
        end
        break;
      end
      if (!bus.busy) busy_bad++;
      if (mode == 1 && !resent && (cap_cnt - base) == 2) begin
        bus.payload = 24'hDEAD00;
        bus.send    = 1'b1;
        @(posedge clk);
        #1;
        bus.send    = 1'b0;
        resent      = 1'b1;
      end
    end
    checkOutput($sformatf("%s frame_done seen", name), 32'(done_ok), 32'd1);
    checkOutput($sformatf("%s busy held", name), 32'(busy_bad), 32'd0);
    repeat (6) @(negedge clk);
    #1;
    checkOutput($sformatf("%s trmt count", name), 32'(cap_cnt - base), 32'd5);
    checkOutput($sformatf("%s frame_done count", name), 32'(fd_cnt - fd0), 32'd1);
    checkOutput($sformatf("%s idle busy", name), 32'(bus.busy), 32'd0);
    s = 8'h00;
    for (int k = 0; k < 5; k++) begin
      if (base + k < 128) begin
        checkOutput($sformatf("%s byte%0d", name, k), 32'(cap[base+k]),
                    32'(exp[39-8*k -: 8]));
        s = s + cap[base+k];
      end
    end
    checkOutput($sformatf("%s byte sum", name), 32'(s), 32'd0);
  endtask

  initial begin
    int   base;
    logic reached;

    vecs[0] = '{payload: 24'h123456, frame: 40'hA5_12_34_56_BF, mode: 0};
    vecs[1] = '{payload: 24'h000000, frame: 40'hA5_00_00_00_5B, mode: 0};
    vecs[2] = '{payload: 24'hFFFFFF, frame: 40'hA5_FF_FF_FF_5E, mode: 0};
    vecs[3] = '{payload: 24'h010203, frame: 40'hA5_01_02_03_55, mode: 2};
    vecs[4] = '{payload: 24'h808080, frame: 40'hA5_80_80_80_DB, mode: 0};
    vecs[5] = '{payload: 24'h123456, frame: 40'hA5_12_34_56_BF, mode: 1};

    bus.send    = 1'b0;
    bus.payload = '0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset trmt", 32'(bus.trmt), 32'd0);
    checkOutput("reset frame_done", 32'(bus.frame_done), 32'd0);
    checkOutput("reset tx_data", 32'(bus.tx_data), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      runFrame($sformatf("vec%0d", i), vecs[i].payload, vecs[i].frame, vecs[i].mode);
    end

    // Reset while waiting on the fourth byte, with tx_done still low.
    base    = cap_cnt;
    reached = 1'b0;
    applyStimulus(24'h123456);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      #1;
      if ((cap_cnt - base) >= 4) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("midrst reached byte3", 32'(reached), 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst trmt", 32'(bus.trmt), 32'd0);
    checkOutput("midrst frame_done", 32'(bus.frame_done), 32'd0);
    checkOutput("midrst tx_data", 32'(bus.tx_data), 32'd0);
    rst = 1'b0;

    // A request while the old byte is still on the line must be dropped.
    base = cap_cnt;
    applyStimulus(24'h123456);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("dropped send trmt", 32'(cap_cnt - base), 32'd0);
    checkOutput("dropped send busy", 32'(bus.busy), 32'd0);

    reached = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_done_m) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("tx_done recovers", 32'(reached), 32'd1);
    runFrame("after rst", 24'h000000, model_frame(24'h000000), 0);

    checkOutput("trmt while tx_done low", 32'(viol_cnt), 32'd0);
    checkOutput("back-to-back trmt", 32'(b2b_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
